branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Sits inside fetch, directly upstream of the if/id register. Supplies predict_taken and predict_target for the current fetch PC.
- Trained by the resolved control-flow outcome from the mem/branch stage: branch_taken, jump_target, pc, and the prediction carried down the pipe.
- Fetch uses the prediction to pick the next PC. A mispredict is detected and flushed in mem/branch, not here.

Parameters:
- INDEX_BITS, 4, log2 of entry count. Legal range 2..8. Entries = 2**INDEX_BITS.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- lookup_pc  in  32  current fetch PC
- predict_taken  out  1  prediction for lookup_pc (combinational)
- predict_target  out  32  predicted next PC (combinational)
- update_valid  in  1  a resolved branch/jump is in mem/branch this cycle
- update_pc  in  32  PC of the resolved instruction
- update_taken  in  1  actual outcome
- update_target  in  32  actual target (meaningful only when update_taken=1)
- update_predict_taken  in  1  prediction that was made for this instruction
- update_predict_target  in  32  target that was predicted
- flush_all  in  1  invalidate every entry (fence.i / context change)

Behaviour:
- Indexing:
  - index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]; pc[1:0] ignored.
  - Per entry: valid (1b), tag, target (30b, word-aligned; low 2 bits are 0 on output), ctr (2b).
- Lookup, purely combinational on the registered arrays:
  - hit = valid[idx] && tag[idx] == lookup tag.
  - predict_taken = hit && ctr[idx][1].
  - predict_target = predict_taken ? {target[idx],2'b00} : lookup_pc + 32'd4 (mod 2^32; 0xfffffffc wraps to 0x00000000).
- Update, at rising edge when update_valid=1 (idx/tag taken from update_pc):
  - Hit and taken: ctr = sat_inc(ctr); target = update_target[31:2].
  - Hit and not taken: ctr = sat_dec(ctr); target unchanged.
  - Miss and taken: allocate. valid=1, tag, target=update_target[31:2], ctr=2'b10 (weakly taken). Replaces any previous occupant.
  - Miss and not taken: no change (no allocation).
  - Saturation: 11 stays 11 on inc; 00 stays 00 on dec.
- Same-cycle hazards:
  - Lookup and update to the same index in one cycle: lookup returns the pre-update contents. No bypass.
  - flush_all and update_valid in the same cycle: flush wins. All valid=0 and the update is dropped.
- flush_all:
  - Clears every valid bit at the next edge. tag, target and ctr are left unchanged.
  - Lookups return not-taken from the following cycle.
- Reset (asynchronous):
  - All valid=0, all ctr=2'b01; tag/target don't-care.
  - Outputs during and after reset: predict_taken=0, predict_target=lookup_pc+4.
  - Reset asserted mid-update: the update is lost and entries read invalid.
- update_predict_* are consumed only by the optional statistics. Without that feature they are unused and must not affect state.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- When defined, adds output ports:
  - stat_updates (out, 32): number of update_valid cycles not masked by flush_all.
  - stat_mispredicts (out, 32): counted updates where update_predict_taken != update_taken, OR (update_taken && update_predict_target != update_target).
- Counters:
  - Reset to 0; wrap at 2^32.
  - Not cleared by flush_all.
  - A same-cycle flush_all masks that cycle's update from both counters.
- When undefined: no stat ports, no counter flops; block behaviour otherwise identical.

Test Plan:
- Cold start: assert rst, release. lookup_pc=0x00000100 -> predict_taken=0, predict_target=0x00000104.
- Allocate: update_valid, update_pc=0x100, taken=1, target=0x40. Next cycle lookup 0x100 -> taken=1, target=0x00000040.
- Alias: after the allocate above, lookup 0x140 (same index 0, tag differs) -> taken=0, target=0x144. Then a taken update at 0x140 → target 0x80 evicts; lookup 0x100 -> taken=0.
- Hysteresis: allocate 0x100 (ctr=10).
  - Not-taken -> ctr 01, predict_taken=0.
  - Not-taken -> 00; taken -> 01, predict_taken=0.
  - Taken -> 10, predict_taken=1.
  - Taken x3 -> stays 11; single not-taken -> 10, still predicts taken.
- Hazards:
  - Update 0x100 taken with lookup_pc=0x100 in the same cycle -> taken=0 that cycle, 1 next cycle.
  - flush_all together with a taken update at 0x200 -> next cycle lookups 0x100 and 0x200 both taken=0.
  - lookup_pc=0xfffffffc on a miss -> target 0x00000000.
- With BRANCH_PREDICTOR_STATS_EN: 3 updates, one with update_predict_taken=1 and update_taken=0, one taken with predict_target 0x40 vs actual 0x44 -> stat_updates=3, stat_mispredicts=2. Assert rst -> both 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup and mem/branch training bundle for the BTB
interface branch_predictor_if;
    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_predict_taken;
    logic [31:0] update_predict_target;
    logic        flush_all;

    modport master (
        output lookup_pc,
        output update_valid,
        output update_pc,
        output update_taken,
        output update_target,
        output update_predict_taken,
        output update_predict_target,
        output flush_all,
        input  predict_taken,
        input  predict_target
    );

    modport slave (
        input  lookup_pc,
        input  update_valid,
        input  update_pc,
        input  update_taken,
        input  update_target,
        input  update_predict_taken,
        input  update_predict_target,
        input  flush_all,
        output predict_taken,
        output predict_target
    );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters; BRANCH_PREDICTOR_STATS_EN adds update/mispredict counters
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0]        stat_updates,
    output logic [31:0]        stat_mispredicts
`endif
);
    localparam int ENTRIES = 2 ** INDEX_BITS;
    localparam int TAG_W   = 32 - INDEX_BITS - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [29:0]        target_q [ENTRIES];
    logic [29:0]        target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]      lk_tag, up_tag;
    logic                  lk_hit, up_hit;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    assign lk_idx = bp.lookup_pc[INDEX_BITS+1:2];
    assign lk_tag = bp.lookup_pc[31:INDEX_BITS+2];
    assign up_idx = bp.update_pc[INDEX_BITS+1:2];
    assign up_tag = bp.update_pc[31:INDEX_BITS+2];

    // Lookup reads registered state only, so a same-cycle update is not visible.
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign bp.predict_taken  = lk_hit && ctr_q[lk_idx][1];
    assign bp.predict_target = bp.predict_taken ? {target_q[lk_idx], 2'b00}
                                                : bp.lookup_pc + 32'd4;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bp.flush_all) begin
            valid_d = '0;
        end else if (bp.update_valid) begin
            if (up_hit) begin
                if (bp.update_taken) begin
                    ctr_d[up_idx]    = sat_inc(ctr_q[up_idx]);
                    target_d[up_idx] = bp.update_target[31:2];
                end else begin
                    ctr_d[up_idx]    = sat_dec(ctr_q[up_idx]);
                end
            end else if (bp.update_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bp.update_target[31:2];
                ctr_d[up_idx]    = 2'b10;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    // Tag and target are don't-care while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] upd_cnt_q, upd_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;
    logic        counted;
    logic        mispredict;
    logic        unused_bits;

    assign counted    = bp.update_valid && !bp.flush_all;
    assign mispredict = (bp.update_predict_taken != bp.update_taken) ||
                        (bp.update_taken && (bp.update_predict_target != bp.update_target));

    always_comb begin
        upd_cnt_d = upd_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (counted) begin
            upd_cnt_d = upd_cnt_q + 32'd1;
            if (mispredict) begin
                mis_cnt_d = mis_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            upd_cnt_q <= upd_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign stat_updates     = upd_cnt_q;
    assign stat_mispredicts = mis_cnt_q;
    assign unused_bits      = ^bp.update_pc[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{bp.update_pc[1:0], bp.update_target[1:0],
                           bp.update_predict_taken, bp.update_predict_target};
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    branch_predictor_if bp ();

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_updates;
    logic [31:0] stat_mispredicts;
    branch_predictor #(.INDEX_BITS(4)) dut (
        .clk(clk), .rst(rst), .bp(bp),
        .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
    );
`else
    branch_predictor #(.INDEX_BITS(4)) dut (.clk(clk), .rst(rst), .bp(bp));
`endif

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bp.update_valid          = 1'b0;
        bp.update_pc             = 32'h0;
        bp.update_taken          = 1'b0;
        bp.update_target         = 32'h0;
        bp.update_predict_taken  = 1'b0;
        bp.update_predict_target = 32'h0;
        bp.flush_all             = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                             input logic ptaken, input logic [31:0] ptgt);
        bp.update_valid          = 1'b1;
        bp.update_pc             = pc;
        bp.update_taken          = taken;
        bp.update_target         = tgt;
        bp.update_predict_taken  = ptaken;
        bp.update_predict_target = ptgt;
        tick();
        bp.update_valid = 1'b0;
    endtask

    task automatic do_flush();
        bp.flush_all = 1'b1;
        tick();
        bp.flush_all = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bp.lookup_pc = 32'h0000_0100;
        rst = 1'b1;
        #13;
        checks++;
        if (bp.predict_taken !== 1'b0 || bp.predict_target !== 32'h0000_0104) begin
            errors++;
            $display("FAIL reset_during: taken=%0b target=%h expected 0/00000104", bp.predict_taken, bp.predict_target);
        end
        rst = 1'b0;
        tick();
        #1;
        checks++;
        if (bp.predict_taken !== 1'b0 || bp.predict_target !== 32'h0000_0104) begin
            errors++;
            $display("FAIL reset_after: taken=%0b target=%h expected 0/00000104", bp.predict_taken, bp.predict_target);
        end
    endtask

    task automatic test_allocate();
        do_update(32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
        bp.lookup_pc = 32'h100;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b1 || bp.predict_target !== 32'h0000_0040) begin
            errors++;
            $display("FAIL allocate: taken=%0b target=%h expected 1/00000040", bp.predict_taken, bp.predict_target);
        end
    endtask

    task automatic test_alias();
        bp.lookup_pc = 32'h140;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b0 || bp.predict_target !== 32'h0000_0144) begin
            errors++;
            $display("FAIL alias_miss: taken=%0b target=%h expected 0/00000144", bp.predict_taken, bp.predict_target);
        end
        do_update(32'h140, 1'b1, 32'h80, 1'b0, 32'h0);
        bp.lookup_pc = 32'h100;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b0 || bp.predict_target !== 32'h0000_0104) begin
            errors++;
            $display("FAIL alias_evicted: taken=%0b target=%h expected 0/00000104", bp.predict_taken, bp.predict_target);
        end
        bp.lookup_pc = 32'h140;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b1 || bp.predict_target !== 32'h0000_0080) begin
            errors++;
            $display("FAIL alias_new: taken=%0b target=%h expected 1/00000080", bp.predict_taken, bp.predict_target);
        end
    endtask

    task automatic test_hysteresis();
        // Each row: outcome applied to 0x100, then the expected predict_taken.
        logic [1:0] seq [11];
        logic exp_t;
        seq = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
        // seq[i][1]=taken outcome, seq[i][0]=expected prediction after it
        seq[0]  = 2'b11;
        seq[1]  = 2'b00;
        seq[2]  = 2'b00;
        seq[3]  = 2'b00;
        seq[4]  = 2'b10;
        seq[5]  = 2'b11;
        seq[6]  = 2'b11;
        seq[7]  = 2'b11;
        seq[8]  = 2'b11;
        seq[9]  = 2'b01;
        seq[10] = 2'b00;
        bp.lookup_pc = 32'h100;
        for (int i = 0; i < 11; i++) begin
            do_update(32'h100, seq[i][1], 32'h40, 1'b0, 32'h0);
            #1;
            exp_t = seq[i][0];
            checks++;
            if (bp.predict_taken !== exp_t ||
                bp.predict_target !== (exp_t ? 32'h40 : 32'h104)) begin
                errors++;
                $display("FAIL hysteresis[%0d]: taken=%0b target=%h expected taken=%0b", i,
                         bp.predict_taken, bp.predict_target, exp_t);
            end
        end
    endtask

    task automatic test_hazards();
        do_flush();
        bp.lookup_pc = 32'h100;
        bp.update_valid = 1'b1;
        bp.update_pc = 32'h100;
        bp.update_taken = 1'b1;
        bp.update_target = 32'h40;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass: taken=%0b expected 0", bp.predict_taken);
        end
        tick();
        bp.update_valid = 1'b0;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b1 || bp.predict_target !== 32'h40) begin
            errors++;
            $display("FAIL after_update: taken=%0b target=%h expected 1/00000040", bp.predict_taken, bp.predict_target);
        end
        bp.flush_all = 1'b1;
        do_update(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
        bp.flush_all = 1'b0;
        bp.lookup_pc = 32'h100;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL flush_clears: taken=%0b expected 0", bp.predict_taken);
        end
        bp.lookup_pc = 32'h200;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b0 || bp.predict_target !== 32'h204) begin
            errors++;
            $display("FAIL flush_drops_update: taken=%0b target=%h expected 0/00000204", bp.predict_taken, bp.predict_target);
        end
        bp.lookup_pc = 32'hffff_fffc;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b0 || bp.predict_target !== 32'h0000_0000) begin
            errors++;
            $display("FAIL pc_wrap: taken=%0b target=%h expected 0/00000000", bp.predict_taken, bp.predict_target);
        end
    endtask

    task automatic test_back_to_back();
        do_update(32'h108, 1'b0, 32'h900, 1'b1, 32'h900);
        bp.lookup_pc = 32'h108;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b0 || bp.predict_target !== 32'h10c) begin
            errors++;
            $display("FAIL miss_not_taken: taken=%0b target=%h expected 0/0000010c", bp.predict_taken, bp.predict_target);
        end
        do_update(32'h104, 1'b1, 32'h500, 1'b0, 32'h0);
        do_update(32'h108, 1'b1, 32'h603, 1'b0, 32'h0);
        bp.lookup_pc = 32'h104;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b1 || bp.predict_target !== 32'h500) begin
            errors++;
            $display("FAIL b2b_first: taken=%0b target=%h expected 1/00000500", bp.predict_taken, bp.predict_target);
        end
        bp.lookup_pc = 32'h10a;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b1 || bp.predict_target !== 32'h600) begin
            errors++;
            $display("FAIL b2b_second: taken=%0b target=%h expected 1/00000600", bp.predict_taken, bp.predict_target);
        end
    endtask

    task automatic test_reset_mid_update();
        bp.update_valid = 1'b1;
        bp.update_pc = 32'h10c;
        bp.update_taken = 1'b1;
        bp.update_target = 32'h700;
        #2;
        rst = 1'b1;
        tick();
        bp.update_valid = 1'b0;
        rst = 1'b0;
        #1;
        bp.lookup_pc = 32'h10c;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b0 || bp.predict_target !== 32'h110) begin
            errors++;
            $display("FAIL reset_mid_update: taken=%0b target=%h expected 0/00000110", bp.predict_taken, bp.predict_target);
        end
        bp.lookup_pc = 32'h104;
        #1;
        checks++;
        if (bp.predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears: taken=%0b expected 0", bp.predict_taken);
        end
    endtask

`ifdef BRANCH_PREDICTOR_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
        do_update(32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
        do_update(32'h104, 1'b0, 32'h0, 1'b1, 32'h80);
        do_update(32'h108, 1'b1, 32'h44, 1'b1, 32'h40);
        bp.flush_all = 1'b1;
        do_update(32'h10c, 1'b1, 32'h44, 1'b0, 32'h0);
        bp.flush_all = 1'b0;
        checks++;
        if (stat_updates !== 32'd3 || stat_mispredicts !== 32'd2) begin
            errors++;
            $display("FAIL stats_counts: updates=%0d mispredicts=%0d expected 3/2", stat_updates, stat_mispredicts);
        end
        rst = 1'b1;
        #2;
        checks++;
        if (stat_updates !== 32'd0 || stat_mispredicts !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset: updates=%0d mispredicts=%0d expected 0/0", stat_updates, stat_mispredicts);
        end
        rst = 1'b0;
    endtask
`endif

    initial begin
        idle_inputs();
        bp.lookup_pc = 32'h0;
        test_reset();
        test_allocate();
        test_alias();
        test_hysteresis();
        test_hazards();
        test_back_to_back();
        test_reset_mid_update();
`ifdef BRANCH_PREDICTOR_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
